// File: rtl/circle_controller_pkg.sv
// circle_controller_pkg: constants and state encoding shared by the circle
// controller, its screen sweep counter and the drawing datapath.
//   SCREEN_W_DEF / SCREEN_H_DEF / NUM_CIRCLES_DEF : default geometry
//   X_W / Y_W                                     : clear coordinate widths
//   COLOUR_*                                      : colours shared with the datapath
//   S_*                                           : FSM state encoding
package circle_controller_pkg;

    localparam int SCREEN_W_DEF    = 160;
    localparam int SCREEN_H_DEF    = 120;
    localparam int NUM_CIRCLES_DEF = 5;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE        = 4'd0;
    localparam state_t S_CLEAR       = 4'd1;
    localparam state_t S_INIT_CIRCLE = 4'd2;
    localparam state_t S_INIT_VARS   = 4'd3;
    localparam state_t S_PLOT        = 4'd4;
    localparam state_t S_INC_Y       = 4'd5;
    localparam state_t S_UPD_CRIT    = 4'd6;
    localparam state_t S_UPD_X       = 4'd7;
    localparam state_t S_LOOP_CHK    = 4'd8;
    localparam state_t S_NEXT_CIRCLE = 4'd9;
    localparam state_t S_DONE        = 4'd10;

endpackage

// File: rtl/circle_controller_screen_sweep.sv
// screen_sweep: raster counter that walks (x, y) over the whole screen,
// one pixel per enabled cycle, and returns to (0, 0) after the last pixel.
//   clock, resetb : clock and asynchronous active-low reset
//   enable_i      : advance one pixel this cycle
//   x_o, y_o      : current coordinate
//   last_o        : current coordinate is (W-1, H-1)
module screen_sweep
    import circle_controller_pkg::*;
#(
    parameter int W = SCREEN_W_DEF,
    parameter int H = SCREEN_H_DEF
) (
    input  logic           clock,
    input  logic           resetb,
    input  logic           enable_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_wrap;

    assign x_wrap = x_q == X_W'(W - 1);
    assign last_o = x_wrap && y_q == Y_W'(H - 1);
    assign x_o    = x_q;
    assign y_o    = y_q;

    always_comb begin
        x_d = enable_i ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d = (enable_i && x_wrap) ? (last_o ? '0 : y_q + 1'b1) : y_q;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/circle_controller.sv
// circle_controller: Moore FSM that clears the screen and then sequences the
// midpoint-circle datapath through NUM_CIRCLES circles, eight octant pixels
// per step.
//   clock, resetb                 : clock and asynchronous active-low reset
//   start_i                       : level request for a clear + draw run
//   crit_condition_i              : datapath crit <= 0
//   offset_condition_i            : datapath offsety <= offsetx
//   circle_num_i                  : datapath current circle index
//   init_circle_o, load_circle_o  : circle index controls
//   init_vars_o, load_crit_o,
//   load_offsetx_o, load_offsety_o: datapath register controls
//   pixel_o                       : octant select, 1..8 while plotting
//   plot_o                        : VGA write strobe
//   clear_sel_o, clear_x_o,
//   clear_y_o                     : screen-clear source select and coordinate
//   done_o                        : run complete
module circle_controller
    import circle_controller_pkg::*;
#(
    parameter int NUM_CIRCLES = NUM_CIRCLES_DEF,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF
) (
    input  logic           clock,
    input  logic           resetb,
    input  logic           start_i,
    input  logic           crit_condition_i,
    input  logic           offset_condition_i,
    input  logic [2:0]     circle_num_i,
    output logic           init_circle_o,
    output logic           load_circle_o,
    output logic           init_vars_o,
    output logic           load_crit_o,
    output logic           load_offsetx_o,
    output logic           load_offsety_o,
    output logic [3:0]     pixel_o,
    output logic           plot_o,
    output logic           clear_sel_o,
    output logic [X_W-1:0] clear_x_o,
    output logic [Y_W-1:0] clear_y_o,
    output logic           done_o
);

    state_t     state_q, state_d;
    logic [3:0] pixel_q, pixel_d;
    logic       sweep_last;
    logic       last_circle;

    assign last_circle = circle_num_i == 3'(NUM_CIRCLES);

    screen_sweep #(.W(SCREEN_W), .H(SCREEN_H)) u_sweep (
        .clock    (clock),
        .resetb   (resetb),
        .enable_i (state_q == S_CLEAR),
        .x_o      (clear_x_o),
        .y_o      (clear_y_o),
        .last_o   (sweep_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        state_d = start_i ? S_CLEAR : S_IDLE;
            S_CLEAR:       state_d = sweep_last ? S_INIT_CIRCLE : S_CLEAR;
            S_INIT_CIRCLE: state_d = S_INIT_VARS;
            S_INIT_VARS:   state_d = S_PLOT;
            S_PLOT:        state_d = (pixel_q == 4'd8) ? S_INC_Y : S_PLOT;
            S_INC_Y:       state_d = crit_condition_i ? S_UPD_CRIT : S_UPD_X;
            S_UPD_X:       state_d = S_UPD_CRIT;
            S_UPD_CRIT:    state_d = S_LOOP_CHK;
            S_LOOP_CHK:    state_d = offset_condition_i ? S_PLOT : S_NEXT_CIRCLE;
            S_NEXT_CIRCLE: state_d = last_circle ? S_DONE : S_INIT_VARS;
            S_DONE:        state_d = start_i ? S_DONE : S_IDLE;
            default:       state_d = S_IDLE;
        endcase
        // Octant counter restarts at 1 on every entry into PLOT and is 0 elsewhere.
        pixel_d = (state_d == S_PLOT) ? ((state_q == S_PLOT) ? pixel_q + 4'd1 : 4'd1) : 4'd0;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            pixel_q <= pixel_d;
        end
    end

    assign pixel_o        = pixel_q;
    assign plot_o         = state_q == S_CLEAR || state_q == S_PLOT;
    assign clear_sel_o    = state_q == S_CLEAR;
    assign init_circle_o  = state_q == S_INIT_CIRCLE;
    // circle_num is a datapath register, so this stays a function of registered state.
    assign load_circle_o  = state_q == S_INIT_CIRCLE || (state_q == S_NEXT_CIRCLE && !last_circle);
    assign init_vars_o    = state_q == S_INIT_VARS;
    assign load_crit_o    = state_q == S_INIT_VARS || state_q == S_UPD_CRIT;
    assign load_offsetx_o = state_q == S_INIT_VARS || state_q == S_UPD_X;
    assign load_offsety_o = state_q == S_INIT_VARS || state_q == S_INC_Y;
    assign done_o         = state_q == S_DONE;

endmodule

// File: tb/tb_circle_controller.sv
// tb_circle_controller: directed, table-driven bench for circle_controller.
module tb_circle_controller;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       start_i = 1'b0;
    logic       crit_condition_i = 1'b0;
    logic       offset_condition_i = 1'b0;
    logic [2:0] circle_num_i = 3'd1;
    logic       init_circle_o, load_circle_o, init_vars_o, load_crit_o;
    logic       load_offsetx_o, load_offsety_o, plot_o, clear_sel_o, done_o;
    logic [3:0] pixel_o;
    logic [7:0] clear_x_o;
    logic [6:0] clear_y_o;

    int checks = 0;
    int errors = 0;

    // {init_circle, load_circle, init_vars, load_crit, load_offsetx,
    //  load_offsety, plot, clear_sel, done, pixel[3:0]}
    localparam logic [12:0] O_IDLE  = 13'h0000;
    localparam logic [12:0] O_INITC = 13'h1800;
    localparam logic [12:0] O_INITV = 13'h0780;
    localparam logic [12:0] O_PLOT  = 13'h0040;
    localparam logic [12:0] O_INCY  = 13'h0080;
    localparam logic [12:0] O_UPDX  = 13'h0100;
    localparam logic [12:0] O_UPDC  = 13'h0200;
    localparam logic [12:0] O_NEXTL = 13'h0800;
    localparam logic [12:0] O_DONE  = 13'h0010;
    localparam logic [12:0] O_CLEAR = 13'h0060;

    typedef struct {
        logic        start;
        logic        crit;
        logic        off;
        logic [2:0]  cnum;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    circle_controller dut (
        .clock              (clock),
        .resetb             (resetb),
        .start_i            (start_i),
        .crit_condition_i   (crit_condition_i),
        .offset_condition_i (offset_condition_i),
        .circle_num_i       (circle_num_i),
        .init_circle_o      (init_circle_o),
        .load_circle_o      (load_circle_o),
        .init_vars_o        (init_vars_o),
        .load_crit_o        (load_crit_o),
        .load_offsetx_o     (load_offsetx_o),
        .load_offsety_o     (load_offsety_o),
        .pixel_o            (pixel_o),
        .plot_o             (plot_o),
        .clear_sel_o        (clear_sel_o),
        .clear_x_o          (clear_x_o),
        .clear_y_o          (clear_y_o),
        .done_o             (done_o)
    );

    always #5 clock = ~clock;

    function automatic logic [12:0] outs();
        return {init_circle_o, load_circle_o, init_vars_o, load_crit_o, load_offsetx_o,
                load_offsety_o, plot_o, clear_sel_o, done_o, pixel_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input bit s, input bit c, input bit o, input int n,
                                input logic [12:0] e);
        vec_t v;
        v.start = s;
        v.crit  = c;
        v.off   = o;
        v.cnum  = 3'(n);
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    function automatic void add_plot();
        for (int p = 1; p <= 8; p++) add(1, 0, 0, 1, O_PLOT | 13'(p));
    endfunction

    // Checks n consecutive CLEAR cycles starting at (0,0); optionally toggles start.
    task automatic sweep(input string name, input int n, input bit tog);
        int bad = 0;
        int fk = -1;
        logic [12:0] fo = '0;
        logic [7:0] fx = '0;
        logic [6:0] fy = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (tog) start_i = 1'($urandom_range(0, 1));
            #1;
            if (outs() !== O_CLEAR || clear_x_o !== 8'(k % 160) || clear_y_o !== 7'(k / 160)) begin
                bad++;
                if (fk < 0) begin
                    fk = k;
                    fo = outs();
                    fx = clear_x_o;
                    fy = clear_y_o;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cycles, first at cycle %0d got outs=0x%0h (%0d,%0d) expected outs=0x%0h (%0d,%0d)",
                     name, bad, fk, fo, fx, fy, O_CLEAR, fk % 160, fk / 160);
        end
    endtask

    initial begin
        add(1, 0, 0, 1, O_INITC);
        add(1, 0, 0, 1, O_INITV);
        add_plot();
        add(1, 0, 0, 1, O_INCY);
        add(1, 0, 0, 1, O_UPDX);
        add(1, 0, 0, 1, O_UPDC);
        add(1, 0, 1, 1, O_IDLE);
        add_plot();
        add(1, 1, 0, 1, O_INCY);
        add(1, 0, 0, 1, O_UPDC);
        add(1, 0, 0, 1, O_IDLE);
        add(1, 0, 0, 3, O_NEXTL);
        add(1, 0, 0, 3, O_INITV);
        add_plot();
        add(1, 1, 0, 1, O_INCY);
        add(1, 0, 0, 1, O_UPDC);
        add(1, 0, 0, 5, O_IDLE);
        add(1, 0, 0, 5, O_IDLE);
        add(1, 0, 0, 5, O_DONE);
        add(1, 0, 0, 5, O_DONE);
        add(0, 0, 0, 5, O_DONE);
        add(0, 0, 0, 1, O_IDLE);

        #1;
        chk("reset_outs", 32'(outs()), 32'(O_IDLE));
        chk("reset_xy", {clear_x_o, clear_y_o}, 0);
        @(negedge clock);
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk("idle_no_plot", 32'(outs()), 32'(O_IDLE));
        end

        @(negedge clock);
        start_i = 1'b1;
        #1;
        chk("idle_before_start", 32'(outs()), 32'(O_IDLE));
        sweep("clear_sweep_run1", 19200, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clock);
            start_i            = vecs[i].start;
            crit_condition_i   = vecs[i].crit;
            offset_condition_i = vecs[i].off;
            circle_num_i       = vecs[i].cnum;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            if (i == 0) chk("clear_wrap_xy", {clear_x_o, clear_y_o}, 0);
        end

        @(negedge clock);
        start_i = 1'b1;
        circle_num_i = 3'd1;
        #1;
        chk("rerun_idle", 32'(outs()), 32'(O_IDLE));
        sweep("clear_sweep_run2", 19200, 1'b0);
        @(negedge clock);
        #1;
        chk("rerun_init_circle", 32'(outs()), 32'(O_INITC));
        @(negedge clock);
        #1;
        chk("rerun_init_vars", 32'(outs()), 32'(O_INITV));
        for (int p = 1; p <= 5; p++) begin
            @(negedge clock);
            #1;
            chk($sformatf("rerun_plot%0d", p), 32'(outs()), 32'(O_PLOT | 13'(p)));
        end
        #2;
        resetb = 1'b0;
        #1;
        chk("async_reset_plot", 32'(outs()), 32'(O_IDLE));
        @(negedge clock);
        resetb = 1'b1;
        sweep("clear_after_reset", 200, 1'b0);
        #2;
        resetb = 1'b0;
        #1;
        chk("async_reset_clear", {19'(outs()), clear_x_o, clear_y_o}, 0);
        @(negedge clock);
        resetb = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            chk("idle_after_reset", {19'(outs()), clear_x_o, clear_y_o}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/circle_controller.md
CIRCLE_CONTROLLER -- requirements
Module: circle_controller

Interface
REQ-001 Parameters: NUM_CIRCLES, 5, number of circles drawn per run; SCREEN_W, 160, clear width in pixels; SCREEN_H, 120, clear height in pixels.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 resetb  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  level request to clear the screen, then draw all circles.
REQ-005 crit_condition  in  1  datapath flag, 1 when crit <= 0.
REQ-006 offset_condition  in  1  datapath flag, 1 when offsety <= offsetx.
REQ-007 circle_num  in  3  datapath current circle index, 1..NUM_CIRCLES.
REQ-008 init_circle, load_circle  out  1 each  reset circle_num to 1 / load next circle_num.
REQ-009 init_vars, load_crit, load_offsetx, load_offsety  out  1 each  datapath register controls.
REQ-010 pixel  out  4  octant select, 1..8 while plotting, else 0.
REQ-011 plot  out  1  VGA write strobe, one pixel per cycle.
REQ-012 clear_sel  out  1  1 selects clear_x/clear_y and black as VGA source.
REQ-013 clear_x  out  8; clear_y  out  7  screen-clear coordinates.
REQ-014 done  out  1  run complete.

Function
REQ-015 The block SHALL be a Moore FSM; all outputs SHALL decode from the registered state and counters only.
REQ-016 States: IDLE, CLEAR, INIT_CIRCLE, INIT_VARS, PLOT, INC_Y, UPD_CRIT, UPD_X, LOOP_CHK, NEXT_CIRCLE, DONE.
REQ-017 IDLE: all outputs 0; start=1 -> CLEAR next cycle.
REQ-018 CLEAR: plot=1, clear_sel=1; clear_x SHALL increment every cycle, wrap from SCREEN_W-1 to 0, and clear_y SHALL increment on that wrap; after (SCREEN_W-1, SCREEN_H-1) -> INIT_CIRCLE, with both counters returned to 0. Duration: exactly SCREEN_W*SCREEN_H cycles.
REQ-019 INIT_CIRCLE: init_circle=1, load_circle=1 -> INIT_VARS.
REQ-020 INIT_VARS: init_vars=1, load_crit=1, load_offsetx=1, load_offsety=1 -> PLOT, with pixel=1.
REQ-021 PLOT: plot=1; pixel SHALL step 1..8, one per cycle; in the cycle pixel=8 -> INC_Y, with pixel=0.
REQ-022 INC_Y: load_offsety=1 -> UPD_CRIT if crit_condition=1, else -> UPD_X.
REQ-023 UPD_X: load_offsetx=1 -> UPD_CRIT; crit SHALL be updated strictly after offsety and offsetx have registered.
REQ-024 UPD_CRIT: load_crit=1 -> LOOP_CHK.
REQ-025 LOOP_CHK: offset_condition=1 -> PLOT, with pixel=1; else -> NEXT_CIRCLE.
REQ-026 NEXT_CIRCLE: if circle_num = NUM_CIRCLES -> DONE; else load_circle=1, init_circle=0 -> INIT_VARS.
REQ-027 DONE: done=1; hold while start=1; start=0 -> IDLE.
REQ-028 start SHALL be ignored in every state except IDLE and DONE.
REQ-029 At most one of init_circle and init_vars SHALL be active per cycle; plot SHALL never be 1 outside CLEAR and PLOT.

Reset
REQ-030 resetb=0 SHALL immediately force state=IDLE and pixel=0, clear_x=0, clear_y=0, and all 1-bit outputs to 0, including mid-CLEAR or mid-PLOT.
REQ-031 After reset release, no plot SHALL occur until start is sampled 1 in IDLE.

Structure
REQ-032 A shared package SHALL hold the state enum, SCREEN_W/SCREEN_H defaults and the colour constants shared with the datapath.
REQ-033 The clear counter pair SHALL be one sub-module, screen_sweep: enable in; x, y, last out.

Verification
REQ-034 Reset, then start=1 -> first plot with clear_sel=1 at (0,0) one cycle later; exactly 19200 consecutive plot cycles, ending at (159,119); init_circle=1 in the next cycle.
REQ-035 After INIT_VARS -> pixel sequence 1,2,...,8 with plot=1 on 8 consecutive cycles, then load_offsety=1 with plot=0.
REQ-036 crit_condition=0 at INC_Y -> load_offsetx pulses one cycle before load_crit; crit_condition=1 -> load_crit in the cycle after INC_Y and no load_offsetx.
REQ-037 offset_condition=0 at LOOP_CHK with circle_num=5 -> done=1 next-but-one cycle; with circle_num=3 -> load_circle=1, then init_vars=1.
REQ-038 resetb pulsed low during PLOT with pixel=5 -> pixel=0, plot=0 asynchronously; start held 1 after release -> sequence restarts at CLEAR (0,0).
REQ-039 start toggled during CLEAR -> no effect on counters; done, then start=0 -> IDLE; start=1 again -> full rerun.
